rfsh_fetch: RTL

Multi-channel background memory fetcher that steals Z80 refresh cycles (nRFSH low) to read bytes from the shared SDRAM on behalf of slow peripherals such as the tape player, a sample player or a second tape deck. It is the parametrised successor of the single-channel tape refresh fetcher. It adds:
- N request channels with round-robin arbitration
- configurable SDRAM latency
- a per-channel last-address cache
- flush inputs and an abort indication

It sits in the top level between peripheral readers and the `sram` address/rd multiplexer, which selects it whenever nRFSH is low.

---
 rtl/rfsh_fetch_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/rfsh_fetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rfsh_fetch_pkg.sv
// rfsh_fetch_pkg: shared constants and helpers for the refresh-cycle fetcher.
//   - FSM state encodings (IDLE, FETCH, HIT)
//   - legal LATENCY bounds
//   - chan_slice(): bit offset of a channel's address within the packed ch_addr bus
package rfsh_fetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HIT   = 2'd2;

    localparam int unsigned LATENCY_MIN = 2;
    localparam int unsigned LATENCY_MAX = 15;

    function automatic int unsigned chan_slice(input int unsigned i, input int unsigned addr_w);
        return i * addr_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
// Ports:
//   req        in   CHANNELS  request vector
//   last_grant in   GW        index granted most recently
//   grant      out  GW        first requesting index after last_grant (cyclic)
//   any        out  1         at least one request present
module rr_arbiter #(
    parameter int unsigned CHANNELS = 2,
    localparam int unsigned GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [GW-1:0]       last_grant,
    output logic [GW-1:0]       grant,
    output logic                any
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest requester
    // after last_grant is the final assignment.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % CHANNELS;
            if (req[idx]) begin
                grant = idx[GW-1:0];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rfsh_fetch.sv
// rfsh_fetch: steals Z80 refresh cycles to read SDRAM bytes for slow peripherals.
// One fetch (or cache hit) is issued per refresh window, channels served round-robin.
// Ports:
//   clk_sys   in   1                system clock
//   nRESET    in   1                async active-low reset
//   nRFSH     in   1                CPU refresh strobe (low = refresh window)
//   ch_req    in   CHANNELS         per-channel request level
//   ch_addr   in   CHANNELS*ADDR_W  per-channel byte address
//   ch_flush  in   CHANNELS         per-channel cache invalidate pulse
//   ch_data   out  CHANNELS*8       per-channel last fetched byte
//   ch_valid  out  CHANNELS         per-channel data-updated pulse
//   ram_addr  out  ADDR_W           SDRAM address
//   ram_rd    out  1                SDRAM read strobe / bus ownership
//   ram_dout  in   8                SDRAM read data
//   aborted   out  1                fetch cancelled by nRFSH rising
module rfsh_fetch
    import rfsh_fetch_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 25,
    parameter int unsigned LATENCY  = 7,
    parameter int unsigned CACHE_EN = 1
) (
    input  logic                       clk_sys,
    input  logic                       nRESET,
    input  logic                       nRFSH,
    input  logic [CHANNELS-1:0]        ch_req,
    input  logic [CHANNELS*ADDR_W-1:0] ch_addr,
    input  logic [CHANNELS-1:0]        ch_flush,
    output logic [CHANNELS*8-1:0]      ch_data,
    output logic [CHANNELS-1:0]        ch_valid,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic                       ram_rd,
    input  logic [7:0]                 ram_dout,
    output logic                       aborted
);

    localparam int unsigned GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_CNT   = CW'(LATENCY);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [GW-1:0] LAST_INIT = GW'(CHANNELS - 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("rfsh_fetch: LATENCY out of range");
    end

    logic [1:0]          state;
    logic                nrfsh_q;
    logic [CW-1:0]       cnt;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       grant_q;
    logic [CHANNELS-1:0] cache_valid;
    logic [ADDR_W-1:0]   cache_addr [CHANNELS];

    logic [GW-1:0]       arb_grant;
    logic                arb_any;
    logic                refresh_edge;
    logic [ADDR_W-1:0]   sel_addr;
    logic                hit;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req        (ch_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    always_comb begin
        refresh_edge = !nRFSH && nrfsh_q;
        sel_addr     = ch_addr[chan_slice(int'(arb_grant), ADDR_W) +: ADDR_W];
        hit          = (CACHE_EN != 0) && cache_valid[arb_grant]
                       && (sel_addr == cache_addr[arb_grant]);
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state       <= ST_IDLE;
            nrfsh_q     <= 1'b1;
            cnt         <= '0;
            last_grant  <= LAST_INIT;
            grant_q     <= '0;
            cache_valid <= '0;
            for (int i = 0; i < CHANNELS; i++) cache_addr[i] <= '0;
            ch_data     <= '0;
            ch_valid    <= '0;
            ram_addr    <= '0;
            ram_rd      <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            nrfsh_q  <= nRFSH;
            ch_valid <= '0;
            aborted  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Arbitration happens only on the edge cycle, so each window
                    // issues at most one fetch.
                    if (refresh_edge && arb_any) begin
                        grant_q <= arb_grant;
                        if (hit) begin
                            state <= ST_HIT;
                        end else begin
                            ram_addr <= sel_addr;
                            ram_rd   <= 1'b1;
                            cnt      <= LAT_CNT;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    // Window closed early: release the bus; last_grant is kept so
                    // the same channel retries next window.
                    if (nRFSH) begin
                        ram_rd  <= 1'b0;
                        aborted <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end else if (cnt == CNT_ONE) begin
                        ch_data[int'(grant_q)*8 +: 8] <= ram_dout;
                        cache_addr[grant_q]           <= ram_addr;
                        cache_valid[grant_q]          <= 1'b1;
                        ch_valid[grant_q]             <= 1'b1;
                        last_grant                    <= grant_q;
                        ram_rd                        <= 1'b0;
                        cnt                           <= '0;
                        state                         <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_HIT: begin
                    ch_valid[grant_q] <= 1'b1;
                    last_grant        <= grant_q;
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // Placed last so a flush overrides a same-cycle fill.
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_flush[i]) cache_valid[i] <= 1'b0;
            end
        end
    end

endmodule
